gsm_rr_scheduler: RTL and testbench
===================================

GSM_RR_SCHEDULER -- requirements
Module: gsm_rr_scheduler

Interface
REQ-001 Parameter NPORT, default 4: number of requester queues.
REQ-002 Parameter DBITWIDTH, default 32: data word width.
REQ-003 Parameter LBITWIDTH, default 4: packet length field width, located in header bits [LBITWIDTH-1:0].
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-006 clr  in  1  synchronous active-high clear, same effect as reset.
REQ-007 q_empty  in  NPORT  per-queue empty flag from the asyn_fifo read side.
REQ-008 q_data  in  NPORT*DBITWIDTH  per-queue unregistered read data; queue i occupies bits [i*DBITWIDTH +: DBITWIDTH].
REQ-009 q_read  out  NPORT  per-queue read strobe; one word is popped per cycle it is high.
REQ-010 out_valid  out  1  out_data holds a word.
REQ-011 out_ready  in  1  downstream accepts the word; a transfer occurs when out_valid & out_ready.
REQ-012 out_data  out  DBITWIDTH  forwarded word.
REQ-013 out_sop / out_eop  out  1 each  first / last word of the packet.
REQ-014 out_port  out  clog2(NPORT)  index of the granted queue.
REQ-015 busy  out  1  high while state is XFER.

Function
REQ-016 A packet is one header word followed by LEN payload words, where LEN = header[LBITWIDTH-1:0] (0..2^LBITWIDTH-1); the header is forwarded unmodified.
REQ-017 The FSM has two states, IDLE and XFER.
REQ-018 In IDLE, requests are ~q_empty; the winner is the first requesting index searched cyclically from last_gnt+1.
REQ-019 In IDLE with at least one request, the FSM registers gnt = winner and enters XFER on the next edge; with no request it stays in IDLE.
REQ-020 Arbitration latency is 1 cycle: the header can transfer at the earliest one cycle after ~q_empty is sampled in IDLE.
REQ-021 In IDLE, out_valid = 0 and q_read = 0.
REQ-022 In XFER, out_valid = ~q_empty[gnt] and out_data = q_data slice gnt, combinationally.
REQ-023 In XFER, q_read[gnt] = out_valid & out_ready; all other q_read bits are 0.
REQ-024 An empty queue mid-packet stalls the transfer (out_valid = 0); the grant is held and no other queue is served.
REQ-025 Flag first is set on entry to XFER; out_sop = out_valid & first; first clears on the header transfer.
REQ-026 On the header transfer, counter rem loads LEN; each payload transfer decrements rem.
REQ-027 out_eop = out_valid & (first ? LEN==0 : rem==1).
REQ-028 A transfer with out_eop high returns the FSM to IDLE on the next edge and sets last_gnt = gnt; at least one IDLE cycle separates packets.
REQ-029 Deasserting out_ready holds out_data and all state stable, except out_valid, which tracks q_empty.
REQ-030 out_port = gnt in XFER and 0 in IDLE.
REQ-031 rem is LBITWIDTH bits wide and never wraps.

Reset
REQ-032 On rst_n = 0 or clr = 1 at posedge clk: state = IDLE, gnt = 0, last_gnt = NPORT-1 (queue 0 has first priority), rem = 0, first = 0.
REQ-033 During and after reset, all outputs are 0.
REQ-034 Reset or clear mid-packet abandons the packet without an eop; the unread queue words remain in the queue.

Structure
REQ-035 Shared package gsm_sched_pkg holds the FSM state enum (IDLE, XFER) and the LEN field position constants.
REQ-036 One sub-module, rr_pick: a combinational NPORT-wide cyclic priority encoder taking (req, last_gnt) and producing (winner, any).

Verification
REQ-037 After reset, queues 0 and 2 each hold a header with LEN=2 plus 2 words, out_ready=1 -> queue 0 packet delivered (3 words, sop on word 1, eop on word 3), one IDLE cycle, then queue 2 packet.
REQ-038 All 4 queues continuously non-empty, LEN=0 -> grant sequence 0,1,2,3,0; each word has sop=eop=1.
REQ-039 Queue 1 header LEN=3 with queue empty after word 2 for 5 cycles; queue 3 has data -> out_valid=0 for 5 cycles, gnt stays 1, queue 3 not read.
REQ-040 out_ready toggles 1,0,1,0 during a LEN=3 packet -> exactly 4 q_read pulses, no duplicated or dropped word.
REQ-041 clr pulsed on the 2nd payload word of a LEN=5 packet -> next cycle IDLE, busy=0, last_gnt=NPORT-1, arbitration restarts at queue 0.
REQ-042 LEN=15 (maximum) packet -> 16 transfers, eop on the 16th, rem reaches 0 without wrapping.

Source files
------------

// File: rtl/gsm_sched_pkg.sv
// Shared types and constants for the round-robin packet scheduler.
package gsm_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Packet length lives in the low bits of the header word.
  localparam int LEN_LSB = 0;

  function automatic int len_msb(input int lbitwidth);
    return LEN_LSB + lbitwidth - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first requester searched from last_gnt+1 upward.
module rr_pick #(
  parameter int NPORT = 4,
  parameter int PW    = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    last_gnt,
  output logic [PW-1:0]    winner,
  output logic             any
);

  int idx;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner = '0;
    any    = |req;
    idx    = 0;
    for (int i = NPORT; i >= 1; i--) begin
      idx = (int'(last_gnt) + i) % NPORT;
      if (req[idx[PW-1:0]]) winner = idx[PW-1:0];
    end
  end

endmodule

// File: rtl/gsm_rr_scheduler.sv
// Round-robin packet scheduler: grants one queue per packet and forwards
// header plus LEN payload words with valid/ready handshake.
module gsm_rr_scheduler
  import gsm_sched_pkg::*;
#(
  parameter int NPORT     = 4,
  parameter int DBITWIDTH = 32,
  parameter int LBITWIDTH = 4,
  localparam int PW       = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [NPORT-1:0]           q_empty,
  input  logic [NPORT*DBITWIDTH-1:0] q_data,
  output logic [NPORT-1:0]           q_read,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DBITWIDTH-1:0]       out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [PW-1:0]              out_port,
  output logic                       busy
);

  state_t               state, state_d;
  logic [PW-1:0]        gnt, last_gnt, winner;
  logic [LBITWIDTH-1:0] rem, len;
  logic                 first, any, live, xfer, cur_empty;
  logic [DBITWIDTH-1:0] cur_data;

  rr_pick #(.NPORT(NPORT), .PW(PW)) u_pick (
    .req      (~q_empty),
    .last_gnt (last_gnt),
    .winner   (winner),
    .any      (any)
  );

  assign live = rst_n & ~clr;
  assign xfer = out_valid & out_ready;

  always_comb begin
    cur_data  = '0;
    cur_empty = 1'b1;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt == PW'(i)) begin
        cur_data  = q_data[i*DBITWIDTH +: DBITWIDTH];
        cur_empty = q_empty[i];
      end
    end
    len = cur_data[LEN_LSB +: LBITWIDTH];
  end

  // Outputs are forced quiet whenever reset or clear is asserted.
  always_comb begin
    state_d   = state;
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_port  = '0;
    q_read    = '0;
    busy      = 1'b0;
    if (live) begin
      case (state)
        IDLE: if (any) state_d = XFER;
        XFER: begin
          busy      = 1'b1;
          out_port  = gnt;
          out_data  = cur_data;
          out_valid = ~cur_empty;
          out_sop   = out_valid & first;
          out_eop   = out_valid & (first ? (len == '0) : (rem == LBITWIDTH'(1)));
          if (out_valid && out_ready) begin
            q_read[gnt] = 1'b1;
            if (out_eop) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= PW'(NPORT - 1);
      rem      <= '0;
      first    <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && any) begin
        gnt   <= winner;
        first <= 1'b1;
      end
      if (state == XFER && xfer) begin
        if (first) begin
          first <= 1'b0;
          rem   <= len;
        end else if (rem != '0) begin
          rem <= rem - LBITWIDTH'(1);
        end
        if (out_eop) last_gnt <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_gsm_rr_scheduler.sv
// Scoreboard bench for gsm_rr_scheduler: queue model drives the read side,
// a negedge monitor checks every transfer and queued control expectations.
module tb_gsm_rr_scheduler;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst_n, clr, out_ready;
  logic [NP-1:0]     q_empty, q_read;
  logic [NP*DW-1:0]  q_data;
  logic              out_valid, out_sop, out_eop, busy;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_port;

  always #5 clk = ~clk;

  gsm_rr_scheduler #(.NPORT(NP), .DBITWIDTH(DW), .LBITWIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .q_empty(q_empty), .q_data(q_data),
    .q_read(q_read), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_port(out_port), .busy(busy)
  );

  typedef struct packed {logic [1:0] port; logic sop; logic eop; logic [31:0] data;} exp_t;
  typedef struct {string name; logic [63:0] act; logic [63:0] exp;} aux_t;
  typedef struct {string name; logic [41:0] exp; logic [41:0] mask;} ctl_t;

  // obs layout: busy, valid, sop, eop, port[1:0], q_read[3:0], data[31:0]
  localparam logic [41:0] M_ALL = '1;
  localparam logic [41:0] M_CTL = {1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 4'hF, 32'h0};
  localparam logic [41:0] M_HDR = {1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 4'hF, 32'h0};

  logic [DW-1:0] fq [NP][$];
  exp_t          sb[$];
  aux_t          aux_q[$];
  ctl_t          ctl_q[$];
  int            checks = 0;
  int            failures = 0;
  int            rd_cnt[NP];
  logic          prev_eop = 1'b0;
  logic [NP-1:0] pend;

  always @(negedge clk) begin
    logic [41:0]   obs;
    logic [NP-1:0] qexp;
    exp_t e;
    aux_t a;
    ctl_t c;
    obs = {busy, out_valid, out_sop, out_eop, out_port, q_read, out_data};
    while (aux_q.size() > 0) begin
      a = aux_q.pop_front();
      checks++;
      if (a.act !== a.exp) begin
        failures++;
        $display("FAIL %s act=%0h req=%0h", a.name, a.act, a.exp);
      end
    end
    while (ctl_q.size() > 0) begin
      c = ctl_q.pop_front();
      checks++;
      if ((obs & c.mask) !== (c.exp & c.mask)) begin
        failures++;
        $display("FAIL %s act=%0h req=%0h", c.name, obs & c.mask, c.exp & c.mask);
      end
    end
    qexp = (out_valid && out_ready) ? (4'b0001 << out_port) : 4'b0000;
    checks++;
    if (q_read !== qexp) begin
      failures++;
      $display("FAIL q_read act=%b req=%b", q_read, qexp);
    end
    if (prev_eop) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_gap busy act=%b req=0", busy);
      end
    end
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word port=%0d data=%h", out_port, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_port, out_sop, out_eop, out_data} !== e) begin
          failures++;
          $display("FAIL word act=%0d/%b/%b/%h req=%0d/%b/%b/%h", out_port, out_sop,
                   out_eop, out_data, e.port, e.sop, e.eop, e.data);
        end
      end
    end
    prev_eop = out_valid & out_ready & out_eop;
    for (int i = 0; i < NP; i++) rd_cnt[i] += int'(q_read[i]);
  end

  function automatic logic [41:0] cv(bit b, bit v, bit s, bit e, logic [1:0] p, logic [3:0] r);
    return {b, v, s, e, p, r, 32'h0};
  endfunction

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      q_empty[i] = (fq[i].size() == 0);
      q_data[i*DW +: DW] = (fq[i].size() == 0) ? '0 : fq[i][0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    pend = q_read;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++)
      if (pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
  endtask

  function automatic logic [31:0] hdr(int len, int tag);
    return 32'hA000_0000 | (tag << 8) | len;
  endfunction

  function automatic logic [31:0] pay(int k, int tag);
    return 32'hD000_0000 | (tag << 8) | k;
  endfunction

  task automatic pkt(input int p, input int len, input int tag);
    fq[p].push_back(hdr(len, tag));
    for (int k = 1; k <= len; k++) fq[p].push_back(pay(k, tag));
  endtask

  task automatic exp_word(input int p, input logic [31:0] d, input bit s, input bit e);
    sb.push_back({p[1:0], s, e, d});
  endtask

  task automatic exp_pkt(input int p, input int len, input int tag);
    exp_word(p, hdr(len, tag), 1'b1, len == 0);
    for (int k = 1; k <= len; k++) exp_word(p, pay(k, tag), 1'b0, k == len);
  endtask

  task automatic ctl(input string n, input logic [41:0] e, input logic [41:0] m);
    ctl_t c;
    c.name = n; c.exp = e; c.mask = m;
    ctl_q.push_back(c);
  endtask

  task automatic aux(input string n, input logic [63:0] act, input logic [63:0] e);
    aux_t a;
    a.name = n; a.act = act; a.exp = e;
    aux_q.push_back(a);
  endtask

  task automatic drain(input string n, input int maxc);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < maxc) begin
      tick();
      k++;
    end
    aux(n, {sb.size(), busy}, 64'h0);
  endtask

  initial begin
    int n, c0;
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b1;
    q_empty = '1; q_data = '0;
    refresh();
    tick(); tick();

    // Reset holds everything quiet even with non-empty queues
    pkt(0, 2, 1); pkt(2, 2, 2);
    refresh();
    ctl("rst_outs_a", 42'h0, M_ALL); tick();
    ctl("rst_outs_b", 42'h0, M_ALL); tick();

    // Two LEN=2 packets, queue 0 then queue 2
    rst_n = 1'b1;
    exp_pkt(0, 2, 1); exp_pkt(2, 2, 2);
    ctl("arb_idle", cv(0, 0, 0, 0, 2'd0, 4'h0), M_HDR); tick();
    ctl("hdr_latency", cv(1, 1, 1, 0, 2'd0, 4'h1), M_HDR);
    drain("t_len2_drain", 30);

    clr = 1'b1;
    ctl("clr_idle_outs", 42'h0, M_ALL); tick();
    clr = 1'b0;

    // All queues busy, LEN=0: grants rotate 0,1,2,3,0,...
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) begin
        pkt(p, 0, 16 + r*4 + p);
        exp_pkt(p, 0, 16 + r*4 + p);
      end
    refresh();
    drain("t_rr_drain", 40);

    // Queue 1 runs dry after two words; queue 3 must wait
    fq[1].push_back(hdr(3, 48)); fq[1].push_back(pay(1, 48));
    pkt(3, 0, 49);
    exp_pkt(1, 3, 48); exp_pkt(3, 0, 49);
    refresh();
    n = 0;
    while (fq[1].size() != 0 && n < 20) begin tick(); n++; end
    aux("t_stall_w1", fq[1].size(), 0);
    for (int k = 0; k < 5; k++) begin
      ctl("stall", cv(1, 0, 0, 0, 2'd1, 4'h0), M_CTL);
      tick();
    end
    aux("t_stall_q3", fq[3].size(), 1);
    fq[1].push_back(pay(2, 48)); fq[1].push_back(pay(3, 48));
    refresh();
    drain("t_stall_drain", 30);

    // Toggling ready on a LEN=3 packet
    pkt(0, 3, 64); exp_pkt(0, 3, 64);
    c0 = rd_cnt[0];
    refresh();
    for (int k = 0; k < 40 && (sb.size() != 0 || busy); k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    drain("t_toggle_drain", 20);
    aux("t_toggle_reads", rd_cnt[0] - c0, 4);

    // Maximum length packet
    pkt(1, 15, 66); exp_pkt(1, 15, 66);
    refresh();
    drain("t_len15_drain", 60);

    // Clear mid-packet
    pkt(0, 0, 80); exp_pkt(0, 0, 80);
    refresh();
    drain("t_clr_pre", 20);
    pkt(2, 5, 81);
    exp_word(2, hdr(5, 81), 1'b1, 1'b0);
    exp_word(2, pay(1, 81), 1'b0, 1'b0);
    refresh();
    n = 0;
    while (fq[2].size() > 4 && n < 20) begin tick(); n++; end
    aux("t_clr_reach", fq[2].size(), 4);
    clr = 1'b1;
    ctl("clr_outs", 42'h0, M_ALL);
    tick();
    clr = 1'b0;
    aux("t_clr_left", fq[2].size(), 4);
    fq[2].delete();
    pkt(0, 0, 82); pkt(3, 0, 83);
    exp_pkt(0, 0, 82); exp_pkt(3, 0, 83);
    refresh();
    ctl("clr_then_idle", cv(0, 0, 0, 0, 2'd0, 4'h0), M_CTL); tick();
    ctl("clr_restart_q0", cv(1, 1, 1, 1, 2'd0, 4'h1), M_HDR);
    drain("t_clr_drain", 20);

    aux("sb_empty", sb.size(), 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
